// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - I2C write master: START, three bytes with ACK slots, STOP
// Optional bus recovery after reset (9 SCL pulses + STOP) under I2C_BUS_RECOVERY_EN.
module i2c_write_master #(
  parameter int CLK_Freq = 50_000_000,
  parameter int I2C_Freq = 20_000,
  parameter int QDIV     = CLK_Freq / (4 * I2C_Freq)
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] I2C_DATA,
  input  logic        START,
  output logic        END,
  output logic        ACK,
  output logic        I2C_SCL,
  inout  wire         I2C_SDA
);

  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

`ifdef I2C_BUS_RECOVERY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RECOVER} state_t;
  localparam state_t RESET_STATE = S_RECOVER;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t          state, state_n;
  logic [QW-1:0]   qcnt, qcnt_n;
  logic [1:0]      q, q_n;
  logic [3:0]      bit_cnt, bit_n;
  logic [1:0]      byte_cnt, byte_n;
  logic [23:0]     shreg, sh_n;
  logic            ack_r, ack_n;
  logic            end_r, end_n;
  logic            scl_r, scl_n;
  logic            sda_low, sda_low_n;
  logic            tick;
  logic            sda_in;
`ifdef I2C_BUS_RECOVERY_EN
  logic [3:0]      rec_cnt, rec_n;
`endif

  assign tick    = (qcnt == QLAST);
  assign sda_in  = I2C_SDA;
  assign I2C_SDA = sda_low ? 1'b0 : 1'bz;
  assign I2C_SCL = scl_r;
  assign END     = end_r;
  assign ACK     = ack_r;

  // Bus levels for a given state/quarter; returns {scl, sda_low}.
  function automatic logic [1:0] bus_levels(state_t st, logic [1:0] qq, logic [3:0] bc, logic b);
    case (st)
      S_START:   bus_levels = {~qq[0], 1'b1};
      S_BIT:     bus_levels = {qq[1], (bc != 4'd8) && !b};
      S_STOP:    bus_levels = {qq != 2'd0, ~qq[1]};
`ifdef I2C_BUS_RECOVERY_EN
      S_RECOVER: bus_levels = {qq[1], 1'b0};
`endif
      default:   bus_levels = 2'b10;
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    qcnt_n   = qcnt;
    q_n      = q;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    sh_n     = shreg;
    ack_n    = ack_r;
    end_n    = end_r;
`ifdef I2C_BUS_RECOVERY_EN
    rec_n    = rec_cnt;
`endif
    if (state == S_IDLE) begin
      qcnt_n = '0;
      q_n    = 2'd0;
      if (START) begin
        sh_n    = I2C_DATA;
        ack_n   = 1'b0;
        end_n   = 1'b0;
        state_n = S_START;
      end
    end else begin
      qcnt_n = tick ? '0 : qcnt + 1'b1;
      if (tick) begin
        q_n = q + 2'd1;
        case (state)
          S_START: begin
            if (q == 2'd1) begin
              state_n = S_BIT;
              q_n     = 2'd0;
              bit_n   = 4'd0;
              byte_n  = 2'd0;
            end
          end
          S_BIT: begin
            if (q == 2'd2 && bit_cnt == 4'd8 && sda_in)
              ack_n = 1'b1;
            if (q == 2'd3) begin
              if (bit_cnt != 4'd8) begin
                bit_n = bit_cnt + 4'd1;
                sh_n  = {shreg[22:0], 1'b0};
              end else begin
                // a NACK skips the remaining bytes
                bit_n = 4'd0;
                if (byte_cnt == 2'd2 || ack_r)
                  state_n = S_STOP;
                else
                  byte_n = byte_cnt + 2'd1;
              end
            end
          end
          S_STOP: begin
            if (q == 2'd3) begin
              state_n = S_IDLE;
              end_n   = 1'b1;
            end
          end
`ifdef I2C_BUS_RECOVERY_EN
          S_RECOVER: begin
            if (q == 2'd3) begin
              if (rec_cnt == 4'd8) begin
                state_n = S_STOP;
                rec_n   = 4'd0;
              end else begin
                rec_n = rec_cnt + 4'd1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
    {scl_n, sda_low_n} = bus_levels(state_n, q_n, bit_n, sh_n[23]);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= RESET_STATE;
      qcnt     <= '0;
      q        <= 2'd0;
      bit_cnt  <= 4'd0;
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
      ack_r    <= 1'b0;
      end_r    <= 1'b1;
      scl_r    <= 1'b1;
      sda_low  <= 1'b0;
`ifdef I2C_BUS_RECOVERY_EN
      rec_cnt  <= 4'd0;
`endif
    end else begin
      state    <= state_n;
      qcnt     <= qcnt_n;
      q        <= q_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shreg    <= sh_n;
      ack_r    <= ack_n;
      end_r    <= end_n;
      scl_r    <= scl_n;
      sda_low  <= sda_low_n;
`ifdef I2C_BUS_RECOVERY_EN
      rec_cnt  <= rec_n;
`endif
    end
  end

endmodule
